program_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the simple 8-bit CPU. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the CPU's instruction memory. It then supplies the CPU's start address and releases the CPU from hold. An optional trailing XOR checksum gates the release.

---
 rtl/program_loader.sv | 181 ++++++++++++++++++
 tb/tb_program_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time loader feeding the 8-bit CPU's instruction memory.
// Accepts a byte stream (base address, word count, N big-endian words and an
// optional XOR checksum), writes 16-bit words to instruction memory, then
// publishes the start address and releases the CPU from hold.
//
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing XOR checksum
// byte gates the release; mismatch raises load_err and keeps the CPU held).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   byte_in/valid     incoming stream byte and its valid flag
//   byte_ready        loader accepts a byte this cycle (registered)
//   restart           synchronous abort/reload request
//   mem_we/addr/wdata instruction memory write port (one-cycle strobe)
//   initial_addr      CPU start address (stream byte 0)
//   cpu_hold          holds the CPU in reset while 1
//   load_done         program loaded and CPU released
//   load_err          checksum mismatch (tied 0 without the checksum feature)
module program_loader #(
  parameter int unsigned MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [MEM_AW-1:0] initial_addr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR_ADDR, S_HDR_CNT, S_DATA_HI, S_DATA_LO, S_FLUSH, S_DONE, S_CHK, S_ERR
  } state_t;
  localparam state_t S_END = S_CHK;
`else
  typedef enum logic [2:0] {
    S_HDR_ADDR, S_HDR_CNT, S_DATA_HI, S_DATA_LO, S_FLUSH, S_DONE
  } state_t;
  localparam state_t S_END = S_FLUSH;
`endif

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_ready_next;

  logic                r_byte_ready;
  logic                r_mem_we;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic [MEM_AW-1:0]   r_initial_addr;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic [MEM_AW-1:0]   r_ptr;
  logic [BYTE_W-1:0]   r_remain;
  logic [BYTE_W-1:0]   r_hi;

  // restart wins over a same-cycle byte offer
  assign w_accept = byte_valid & r_byte_ready & ~restart;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_HDR_ADDR;
    else     r_state <= w_next;
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_csum;
  logic              r_load_err;
`endif

  // next-state logic
  always_comb begin
    w_next = r_state;
    if (restart) begin
      w_next = S_HDR_ADDR;
    end else begin
      case (r_state)
        S_HDR_ADDR: if (w_accept) w_next = S_HDR_CNT;
        S_HDR_CNT:  if (w_accept) w_next = (byte_in == 8'd0) ? S_END : S_DATA_HI;
        S_DATA_HI:  if (w_accept) w_next = S_DATA_LO;
        S_DATA_LO:  if (w_accept) w_next = (r_remain == 8'd1) ? S_END : S_DATA_HI;
        S_FLUSH:    w_next = S_DONE;
        S_DONE:     w_next = S_DONE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK:      if (w_accept) w_next = (byte_in == r_csum) ? S_DONE : S_ERR;
        S_ERR:      w_next = S_ERR;
`endif
        default:    w_next = S_HDR_ADDR;
      endcase
    end
  end

  // byte_ready is registered, so it is derived from the state being entered
  always_comb begin
    w_ready_next = (w_next == S_HDR_ADDR) || (w_next == S_HDR_CNT) ||
                   (w_next == S_DATA_HI)  || (w_next == S_DATA_LO);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (w_next == S_CHK) w_ready_next = 1'b1;
`endif
  end

  // datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_ready   <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_initial_addr <= '0;
      r_cpu_hold     <= 1'b1;
      r_load_done    <= 1'b0;
      r_ptr          <= '0;
      r_remain       <= '0;
      r_hi           <= '0;
    end else begin
      r_byte_ready <= w_ready_next;
      r_mem_we     <= 1'b0;
      r_cpu_hold   <= (w_next != S_DONE);
      r_load_done  <= (w_next == S_DONE);
      if (restart) begin
        r_ptr    <= '0;
        r_remain <= '0;
      end else if (w_accept) begin
        case (r_state)
          S_HDR_ADDR: begin
            r_initial_addr <= MEM_AW'(byte_in);
            r_ptr          <= MEM_AW'(byte_in);
          end
          S_HDR_CNT: r_remain <= byte_in;
          S_DATA_HI: r_hi     <= byte_in;
          S_DATA_LO: begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_ptr;
            r_mem_wdata <= {r_hi, byte_in};
            // pointer wraps modulo 2^MEM_AW
            r_ptr       <= r_ptr + MEM_AW'(1);
            r_remain    <= r_remain - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  // running XOR of every header and data byte; the checksum byte itself is excluded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csum     <= '0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= (w_next == S_ERR);
      if (restart)                          r_csum <= '0;
      else if (w_accept && r_state != S_CHK) r_csum <= r_csum ^ byte_in;
    end
  end
  assign load_err = r_load_err;
`else
  assign load_err = 1'b0;
`endif

  assign byte_ready   = r_byte_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign initial_addr = r_initial_addr;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized + directed bench for program_loader with a
// stream-position reference model and a per-cycle output compare process.
module tb_program_loader;

  localparam int unsigned AW = 8;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          restart = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [AW-1:0] initial_addr;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  program_loader #(.MEM_AW(AW)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .restart(restart), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .initial_addr(initial_addr),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many stream bytes have been consumed and
  // derives every output from the stream position.
  bit          m_started, m_flush, m_done, m_err;
  int          m_k;
  logic [7:0]  m_b, m_n, m_cs, m_hi;
  logic        e_we;
  logic [7:0]  e_addr, e_init;
  logic [15:0] e_wdata;

  function automatic bit m_ready();
    return m_started && !m_flush && !m_done && !m_err;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_flush = 0; m_done = 0; m_err = 0; m_k = 0;
      m_b = 0; m_n = 0; m_cs = 0; m_hi = 0;
      e_we = 0; e_addr = 0; e_init = 0; e_wdata = 0;
    end else begin
      bit acc;
      int idx;
      int last;
      acc  = byte_valid && m_ready() && !restart;
      e_we = 0;
      last = 2 + 2 * int'(m_n);
      if (restart) begin
        m_k = 0; m_cs = 0; m_flush = 0; m_done = 0; m_err = 0;
      end else if (m_flush) begin
        m_flush = 0; m_done = 1;
      end else if (acc) begin
        if (m_k == 0) begin
          m_b = byte_in; e_init = byte_in; m_cs ^= byte_in; m_k = 1;
        end else if (m_k == 1) begin
          m_n = byte_in; m_cs ^= byte_in; m_k = 2;
          if (byte_in == 8'd0 && !CSUM) m_flush = 1;
        end else if (m_k < last) begin
          idx = m_k - 2;
          m_cs ^= byte_in;
          if (idx % 2 == 0) m_hi = byte_in;
          else begin
            e_we = 1;
            e_addr = 8'(int'(m_b) + idx / 2);
            e_wdata = {m_hi, byte_in};
          end
          m_k++;
          if (m_k == last && !CSUM) m_flush = 1;
        end else begin
          if (byte_in == m_cs) m_done = 1;
          else m_err = 1;
        end
      end
      m_started = 1;
    end
  end

  // write log of what the DUT actually did, for the directed literal checks
  logic [7:0]  log_a[$];
  logic [15:0] log_d[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("byte_ready",   byte_ready,   m_ready());
      chk("mem_we",       mem_we,       e_we);
      chk("mem_addr",     mem_addr,     e_addr);
      chk("mem_wdata",    mem_wdata,    e_wdata);
      chk("initial_addr", initial_addr, e_init);
      chk("cpu_hold",     cpu_hold,     !m_done);
      chk("load_done",    load_done,    m_done);
      chk("load_err",     load_err,     m_err);
      if (mem_we) begin
        log_a.push_back(mem_addr);
        log_d.push_back(mem_wdata);
      end
    end
  end

  function automatic bq_t with_cs(input bq_t q);
    logic [7:0] c = 8'h00;
    bq_t r = q;
    foreach (q[i]) c ^= q[i];
    if (CSUM) r.push_back(c);
    return r;
  endfunction

  // gaps: 0 = back-to-back, 1 = valid every other cycle, 2 = random
  task automatic send(input bq_t q, input int gaps);
    int i = 0;
    int cyc = 0;
    while (i < q.size() && cyc < 2000) begin
      @(negedge clk);
      byte_valid = 1'b1;
      if (gaps == 1 && cyc % 2 == 1) byte_valid = 1'b0;
      if (gaps == 2 && $urandom_range(0, 2) == 0) byte_valid = 1'b0;
      byte_in = byte_valid ? q[i] : 8'($urandom);
      if (byte_valid && byte_ready) i++;
      cyc++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (i < q.size()) chk("send_timeout", 32'(i), 32'(q.size()));
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(m_done || m_err) && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!(m_done || m_err)) chk("end_timeout", 32'(c), 32'd0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1; byte_valid = 1'b1; byte_in = 8'h5A;
    @(negedge clk);
    restart = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, byte_ready, 1'b0);
    chk({tag, "_we"},    mem_we, 1'b0);
    chk({tag, "_addr"},  mem_addr, 8'h00);
    chk({tag, "_wdata"}, mem_wdata, 16'h0000);
    chk({tag, "_init"},  initial_addr, 8'h00);
    chk({tag, "_hold"},  cpu_hold, 1'b1);
    chk({tag, "_done"},  load_done, 1'b0);
    chk({tag, "_err"},   load_err, 1'b0);
  endtask

  initial begin
    int base;
    bq_t q;

    #1 rst = 1'b1;
    #2 chk_reset_vals("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // basic load
    base = log_a.size();
    send(with_cs('{8'h10, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4}), 0);
    wait_end();
    @(negedge clk);
    chk("basic_n",  32'(log_a.size() - base), 32'd2);
    if (log_a.size() >= base + 2) begin
      chk("basic_a0", log_a[base],     8'h10);
      chk("basic_d0", log_d[base],     16'hA1B2);
      chk("basic_a1", log_a[base + 1], 8'h11);
      chk("basic_d1", log_d[base + 1], 16'hC3D4);
    end
    chk("basic_init", initial_addr, 8'h10);
    chk("basic_done", load_done, 1'b1);
    chk("basic_hold", cpu_hold, 1'b0);

    // same stream with valid toggling, then bytes after DONE are ignored
    do_restart();
    base = log_a.size();
    send(with_cs('{8'h10, 8'h02, 8'hA1, 8'hB2, 8'hC3, 8'hD4}), 1);
    wait_end();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      byte_valid = 1'b1; byte_in = 8'($urandom);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("gap_n", 32'(log_a.size() - base), 32'd2);
    if (log_a.size() >= base + 2) chk("gap_d1", log_d[base + 1], 16'hC3D4);
    chk("gap_ready_after_done", byte_ready, 1'b0);
    chk("gap_done", load_done, 1'b1);

    // wrap-around
    do_restart();
    base = log_a.size();
    send(with_cs('{8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}), 0);
    wait_end();
    @(negedge clk);
    chk("wrap_n", 32'(log_a.size() - base), 32'd3);
    if (log_a.size() >= base + 3) begin
      chk("wrap_a0", log_a[base],     8'hFE);
      chk("wrap_a1", log_a[base + 1], 8'hFF);
      chk("wrap_a2", log_a[base + 2], 8'h00);
      chk("wrap_d2", log_d[base + 2], 16'h0506);
    end
    chk("wrap_done", load_done, 1'b1);

    if (CSUM) begin
      do_restart();
      send('{8'h20, 8'h01, 8'h12, 8'h34, 8'h06}, 0);
      wait_end();
      @(negedge clk);
      chk("cs_bad_err",  load_err, 1'b1);
      chk("cs_bad_hold", cpu_hold, 1'b1);
      chk("cs_bad_done", load_done, 1'b0);
      do_restart();
      send('{8'h20, 8'h01, 8'h12, 8'h34, 8'h07}, 0);
      wait_end();
      @(negedge clk);
      chk("cs_ok_done", load_done, 1'b1);
      chk("cs_ok_err",  load_err, 1'b0);
    end

    // restart after the first data byte
    do_restart();
    base = log_a.size();
    send('{8'h10, 8'h02, 8'hA1}, 0);
    do_restart();
    @(negedge clk);
    chk("rs_nowrite", 32'(log_a.size() - base), 32'd0);
    chk("rs_ready", byte_ready, 1'b1);
    send(with_cs('{8'h40, 8'h00}), 0);
    wait_end();
    @(negedge clk);
    chk("rs_init", initial_addr, 8'h40);
    chk("rs_done", load_done, 1'b1);

    // asynchronous reset while waiting in the low-byte state
    do_restart();
    base = log_a.size();
    send('{8'h10, 8'h02, 8'hA1}, 0);
    @(negedge clk);
    byte_valid = 1'b1; byte_in = 8'hB2;
    #2 rst = 1'b1;
    #1 chk_reset_vals("arst");
    #1 rst = 1'b0;
    @(negedge clk);
    byte_valid = 1'b0;
    @(negedge clk);
    chk("arst_nowrite", 32'(log_a.size() - base), 32'd0);

    // randomized loads
    for (int t = 0; t < 40; t++) begin
      int n;
      logic [7:0] b;
      do_restart();
      n = $urandom_range(0, 5);
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hFC, 8'hFF)) : 8'($urandom);
      q = '{b, 8'(n)};
      for (int j = 0; j < 2 * n; j++) q.push_back(8'($urandom));
      q = with_cs(q);
      if (CSUM && $urandom_range(0, 3) == 0) q[q.size() - 1] ^= 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) begin
        send(q[0:$urandom_range(0, q.size() - 1)], 2);
        do_restart();
      end else begin
        send(q, $urandom_range(0, 2));
        wait_end();
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
